puzzle_board: RTL and testbench
===============================

PUZZLE_BOARD -- requirements
Module: puzzle_board

Interface
REQ-001 Parameter CNT_W, default 10, width of move_count.
REQ-002 clk  input  1  pixel-domain clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 move_valid  input  1  move request strobe.
REQ-005 move_dir  input  2  blank travel direction: 0 up (idx-4), 1 down (idx+4), 2 left (idx-1), 3 right (idx+1).
REQ-006 move_ready  output  1  high only in IDLE with load_en low; a move is accepted on an edge where move_valid and move_ready are both high.
REQ-007 load_en  input  1  board load strobe, honoured only in IDLE.
REQ-008 load_board  input  64  load data; bits [4i+3:4i] give the tile for position i.
REQ-009 vblank  input  1  high during vertical blanking; swaps commit only while it is high.
REQ-010 posA..posP  output  4 each  registered tile values for positions 0..15, row-major; 0 means blank.
REQ-011 blank_idx  output  4  position of the blank.
REQ-012 move_done  output  1  one-cycle pulse per committed move.
REQ-013 move_rej  output  1  one-cycle pulse per illegal move.
REQ-014 move_count  output  CNT_W  number of committed moves, saturating.
REQ-015 solved  output  1  high when the board is in solved order.

Function
REQ-016 The block SHALL implement the states IDLE, CHECK, WAIT_VB, SWAP_DONE and REJ.
REQ-017 IDLE: load_en high SHALL take priority over move_valid; the board is loaded that edge, blank_idx is set to the lowest position holding 0 (15 if no position holds 0), move_count is cleared, and the state stays IDLE.
REQ-018 IDLE with an accepted move SHALL latch move_dir and go to CHECK.
REQ-019 CHECK SHALL flag a move as illegal when: up and blank row=0; down and row=3; left and col=0; right and col=3.
REQ-020 CHECK SHALL go to REJ on an illegal move and to WAIT_VB on a legal one; the neighbour index is registered on that same edge.
REQ-021 REJ SHALL assert move_rej for exactly one cycle, leave the board and move_count unchanged, and return to IDLE.
REQ-022 WAIT_VB SHALL hold while vblank=0.
REQ-023 WAIT_VB on an edge with vblank=1 SHALL, in a single edge:
- set pos[blank] to pos[nbr] and pos[nbr] to 0;
- set blank_idx to nbr;
- increment move_count, saturating at 2^CNT_W-1;
- go to SWAP_DONE.
REQ-024 SWAP_DONE SHALL assert move_done for exactly one cycle, then return to IDLE.
REQ-025 With vblank held high, a swap SHALL be visible on posX after the second edge following acceptance, and move_ready SHALL be high again after the third edge.
REQ-026 solved SHALL be a registered signal, updated every edge from the current board, equal to 1 iff pos[i]=i+1 for i=0..14 and pos[15]=0.
REQ-027 move_valid, move_dir and load_en SHALL be ignored outside IDLE; no requests are queued.
REQ-028 move_done and move_rej SHALL never be high in the same cycle.

Reset
REQ-029 rst high SHALL force, on the next edge regardless of state, including mid-WAIT_VB (the pending move is dropped):
- state IDLE;
- board A..P = 3,15,4,11,1,10,7,14,9,5,8,0,2,12,13,6;
- blank_idx=11, move_count=0, move_done=0, move_rej=0, solved=0.
REQ-030 move_ready SHALL be 0 while rst is high.

Verification
REQ-031 Reset, then idle 2 cycles -> posA..posP equal the REQ-029 values, blank_idx=11, move_count=0, move_ready=1.
REQ-032 After reset, vblank=1, move up -> posH=0, posL=14, blank_idx=7, move_count=1, a single move_done pulse, no move_rej.
REQ-033 After reset, move right (blank in col 3) -> one move_rej pulse, board unchanged, move_count=0.
REQ-034 After reset, vblank=0, move left -> no board change for 20 cycles; after vblank rises -> posK=0, posL=8, move_done one cycle later.
REQ-035 Load the solved board with positions 14 and 15 swapped (blank at 14), then move right with vblank=1 -> solved=1, move_count=1; a following move down -> move_rej pulse, solved stays 1.
REQ-036 Accept a move with vblank=0, assert rst while in WAIT_VB, then raise vblank -> board equals the REQ-029 values, no move_done pulse, move_count=0.

Source files
------------

// File: rtl/puzzle_board.sv
// 4x4 sliding-tile puzzle board. Moves are requested by the direction the
// blank travels; a legal move commits its swap only during vertical blanking
// so the displayed board never tears mid-frame.
module puzzle_board #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             move_valid,
    input  logic [1:0]       move_dir,
    output logic             move_ready,
    input  logic             load_en,
    input  logic [63:0]      load_board,
    input  logic             vblank,
    output logic [3:0]       posA,
    output logic [3:0]       posB,
    output logic [3:0]       posC,
    output logic [3:0]       posD,
    output logic [3:0]       posE,
    output logic [3:0]       posF,
    output logic [3:0]       posG,
    output logic [3:0]       posH,
    output logic [3:0]       posI,
    output logic [3:0]       posJ,
    output logic [3:0]       posK,
    output logic [3:0]       posL,
    output logic [3:0]       posM,
    output logic [3:0]       posN,
    output logic [3:0]       posO,
    output logic [3:0]       posP,
    output logic [3:0]       blank_idx,
    output logic             move_done,
    output logic             move_rej,
    output logic [CNT_W-1:0] move_count,
    output logic             solved
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_WAIT_VB   = 3'd2,
        ST_SWAP_DONE = 3'd3,
        ST_REJ       = 3'd4
    } state_t;

    // Power-on scramble, position 0 in the low nibble.
    localparam logic [15:0][3:0] RESET_BOARD = {
        4'd6, 4'd13, 4'd12, 4'd2, 4'd0, 4'd8, 4'd5, 4'd9,
        4'd14, 4'd7, 4'd10, 4'd1, 4'd11, 4'd4, 4'd15, 4'd3
    };

    localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] COUNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [15:0][3:0]       board_q, board_d;
    logic [3:0]             blank_q, blank_d;
    logic [3:0]             nbr_q, nbr_d;
    logic [1:0]             dir_q, dir_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   done_q, done_d;
    logic                   rej_q, rej_d;
    logic                   solved_q, solved_d;

    // True when tiles 1..15 sit in positions 0..14 and the blank is last.
    function automatic logic board_is_solved(input logic [15:0][3:0] b);
        logic ok;
        ok = (b[15] == 4'd0);
        for (int i = 0; i < 15; i++) begin
            if (b[i] != 4'(i + 1)) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // Lowest position holding the blank; a board without one parks it at 15.
    function automatic logic [3:0] first_blank(input logic [15:0][3:0] b);
        logic [3:0] idx;
        logic       found;
        idx   = 4'd15;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found && (b[i] == 4'd0)) begin
                idx   = 4'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    // A move is illegal when the blank would leave the 4x4 grid.
    function automatic logic move_illegal(input logic [1:0] dir, input logic [3:0] blank);
        logic bad;
        case (dir)
            2'd0:    bad = (blank[3:2] == 2'd0);
            2'd1:    bad = (blank[3:2] == 2'd3);
            2'd2:    bad = (blank[1:0] == 2'd0);
            2'd3:    bad = (blank[1:0] == 2'd3);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Index the blank moves to; only meaningful for legal moves.
    function automatic logic [3:0] neighbour(input logic [1:0] dir, input logic [3:0] blank);
        logic [3:0] n;
        case (dir)
            2'd0:    n = blank - 4'd4;
            2'd1:    n = blank + 4'd4;
            2'd2:    n = blank - 4'd1;
            2'd3:    n = blank + 4'd1;
            default: n = blank;
        endcase
        return n;
    endfunction

    // Next-state, board update and pulse generation.
    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        blank_d  = blank_q;
        nbr_d    = nbr_q;
        dir_d    = dir_q;
        count_d  = count_q;
        done_d   = 1'b0;
        rej_d    = 1'b0;
        solved_d = board_is_solved(board_q);
        case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    board_d = load_board;
                    blank_d = first_blank(load_board);
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (move_valid) begin
                    dir_d   = move_dir;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                nbr_d = neighbour(dir_q, blank_q);
                if (move_illegal(dir_q, blank_q)) begin
                    rej_d   = 1'b1;
                    state_d = ST_REJ;
                end else begin
                    state_d = ST_WAIT_VB;
                end
            end
            ST_WAIT_VB: begin
                if (vblank) begin
                    board_d[blank_q] = board_q[nbr_q];
                    board_d[nbr_q]   = 4'd0;
                    blank_d          = nbr_q;
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + COUNT_ONE;
                    end else begin
                        count_d = count_q;
                    end
                    done_d  = 1'b1;
                    state_d = ST_SWAP_DONE;
                end else begin
                    state_d = ST_WAIT_VB;
                end
            end
            ST_SWAP_DONE: state_d = ST_IDLE;
            ST_REJ:       state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State and board registers with synchronous reset to the scramble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            board_q  <= RESET_BOARD;
            blank_q  <= 4'd11;
            nbr_q    <= 4'd0;
            dir_q    <= 2'd0;
            count_q  <= '0;
            done_q   <= 1'b0;
            rej_q    <= 1'b0;
            solved_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            blank_q  <= blank_d;
            nbr_q    <= nbr_d;
            dir_q    <= dir_d;
            count_q  <= count_d;
            done_q   <= done_d;
            rej_q    <= rej_d;
            solved_q <= solved_d;
        end
    end

    // Ready is withheld during reset and while a load is being requested.
    always_comb begin
        move_ready = (state_q == ST_IDLE) && !load_en && !rst;
    end

    assign posA       = board_q[0];
    assign posB       = board_q[1];
    assign posC       = board_q[2];
    assign posD       = board_q[3];
    assign posE       = board_q[4];
    assign posF       = board_q[5];
    assign posG       = board_q[6];
    assign posH       = board_q[7];
    assign posI       = board_q[8];
    assign posJ       = board_q[9];
    assign posK       = board_q[10];
    assign posL       = board_q[11];
    assign posM       = board_q[12];
    assign posN       = board_q[13];
    assign posO       = board_q[14];
    assign posP       = board_q[15];
    assign blank_idx  = blank_q;
    assign move_done  = done_q;
    assign move_rej   = rej_q;
    assign move_count = count_q;
    assign solved     = solved_q;

endmodule

// File: tb/tb_puzzle_board.sv
// Scoreboard bench for puzzle_board: each issued move pushes its expected
// outcome; the monitor pops and compares on every done/rej pulse.
module tb_puzzle_board;

    localparam int CNT_W = 10;
    localparam int CMAX  = 1023;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             move_valid = 1'b0;
    logic [1:0]       move_dir = 2'd0;
    logic             move_ready;
    logic             load_en = 1'b0;
    logic [63:0]      load_board = 64'd0;
    logic             vblank = 1'b0;
    logic [3:0]       posA, posB, posC, posD, posE, posF, posG, posH;
    logic [3:0]       posI, posJ, posK, posL, posM, posN, posO, posP;
    logic [3:0]       blank_idx;
    logic             move_done, move_rej;
    logic [CNT_W-1:0] move_count;
    logic             solved;

    puzzle_board #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .move_valid(move_valid), .move_dir(move_dir),
        .move_ready(move_ready), .load_en(load_en), .load_board(load_board),
        .vblank(vblank),
        .posA(posA), .posB(posB), .posC(posC), .posD(posD),
        .posE(posE), .posF(posF), .posG(posG), .posH(posH),
        .posI(posI), .posJ(posJ), .posK(posK), .posL(posL),
        .posM(posM), .posN(posN), .posO(posO), .posP(posP),
        .blank_idx(blank_idx), .move_done(move_done), .move_rej(move_rej),
        .move_count(move_count), .solved(solved)
    );

    always #5 clk = ~clk;

    localparam logic [15:0][3:0] RST_BOARD = {
        4'd6, 4'd13, 4'd12, 4'd2, 4'd0, 4'd8, 4'd5, 4'd9,
        4'd14, 4'd7, 4'd10, 4'd1, 4'd11, 4'd4, 4'd15, 4'd3
    };

    typedef struct {
        logic        is_done;
        logic [63:0] board;
        logic [3:0]  blank;
        int          count;
    } exp_t;

    exp_t             sb[$];
    logic [15:0][3:0] mb;
    int               mblank;
    int               mcount;
    int               errs = 0;
    int               checks = 0;
    int               ndone = 0;
    int               nrej = 0;
    int               exp_done = 0;
    int               exp_rej = 0;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] dut_board();
        return {posP, posO, posN, posM, posL, posK, posJ, posI,
                posH, posG, posF, posE, posD, posC, posB, posA};
    endfunction

    // Compare each completion pulse against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (move_done || move_rej) begin
            chk_eq("done_rej_excl", {63'd0, move_done & move_rej}, 64'd0);
            if (move_done) ndone++;
            if (move_rej) nrej++;
            if (sb.size() == 0) begin
                chk_eq("unexpected_event", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_eq("ev_kind", {63'd0, move_done}, {63'd0, e.is_done});
                chk_eq("ev_board", dut_board(), e.board);
                chk_eq("ev_blank", {60'd0, blank_idx}, {60'd0, e.blank});
                chk_eq("ev_count", 64'(move_count), 64'(e.count));
            end
        end
    end

    task automatic model_reset();
        mb     = RST_BOARD;
        mblank = 11;
        mcount = 0;
        sb.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        chk_eq("ready_in_rst", {63'd0, move_ready}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!move_ready && n < 50);
        if (!move_ready) chk_eq(tag, {63'd0, move_ready}, 64'd1);
    endtask

    task automatic issue(input logic [1:0] dir);
        exp_t e;
        int   nbr;
        logic legal;
        case (dir)
            2'd0:    begin legal = (mblank >= 4);      nbr = mblank - 4; end
            2'd1:    begin legal = (mblank < 12);      nbr = mblank + 4; end
            2'd2:    begin legal = (mblank % 4 != 0);  nbr = mblank - 1; end
            default: begin legal = (mblank % 4 != 3);  nbr = mblank + 1; end
        endcase
        if (legal) begin
            mb[mblank] = mb[nbr];
            mb[nbr]    = 4'd0;
            mblank     = nbr;
            if (mcount < CMAX) mcount++;
            exp_done++;
        end else begin
            exp_rej++;
        end
        e.is_done = legal;
        e.board   = mb;
        e.blank   = 4'(mblank);
        e.count   = mcount;
        wait_ready("ready_timeout");
        sb.push_back(e);
        move_valid = 1'b1;
        move_dir   = dir;
        @(posedge clk); #1;
        move_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic load(input logic [63:0] b, input logic [3:0] exp_blank);
        @(negedge clk);
        load_en    = 1'b1;
        load_board = b;
        move_valid = 1'b1;
        move_dir   = 2'd0;
        #1;
        chk_eq("ready_during_load", {63'd0, move_ready}, 64'd0);
        @(posedge clk); #1;
        load_en    = 1'b0;
        move_valid = 1'b0;
        mb         = b;
        mblank     = exp_blank;
        mcount     = 0;
        repeat (3) @(negedge clk);
        chk_eq("load_board", dut_board(), mb);
        chk_eq("load_blank", {60'd0, blank_idx}, {60'd0, exp_blank});
        chk_eq("load_count", 64'(move_count), 64'd0);
    endtask

    initial begin
        logic [63:0]      pre;
        logic             changed;
        logic [15:0][3:0] sb_board;

        // Reset state
        do_reset();
        repeat (2) @(negedge clk);
        chk_eq("rst_board", dut_board(), RST_BOARD);
        chk_eq("rst_blank", {60'd0, blank_idx}, 64'd11);
        chk_eq("rst_count", 64'(move_count), 64'd0);
        chk_eq("rst_ready", {63'd0, move_ready}, 64'd1);
        chk_eq("rst_solved", {63'd0, solved}, 64'd0);

        // Move up with vblank high, including edge-by-edge latency
        vblank = 1'b1;
        issue(2'd0);
        @(posedge clk); #1;
        chk_eq("lat_e1_posL", {60'd0, posL}, 64'd0);
        @(posedge clk); #1;
        chk_eq("lat_e2_posL", {60'd0, posL}, 64'd14);
        chk_eq("lat_e2_ready", {63'd0, move_ready}, 64'd0);
        @(posedge clk); #1;
        chk_eq("lat_e3_ready", {63'd0, move_ready}, 64'd1);
        drain("up_drain");
        chk_eq("up_posH", {60'd0, posH}, 64'd0);
        chk_eq("up_blank", {60'd0, blank_idx}, 64'd7);
        chk_eq("up_count", 64'(move_count), 64'd1);

        // Illegal right from column 3
        do_reset();
        issue(2'd3);
        drain("right_rej_drain");
        chk_eq("rej_board", dut_board(), RST_BOARD);
        chk_eq("rej_count", 64'(move_count), 64'd0);

        // Move left waiting for vblank; stray requests in WAIT_VB ignored
        do_reset();
        vblank = 1'b0;
        pre = dut_board();
        issue(2'd2);
        changed = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) begin
                move_valid = 1'b1; move_dir = 2'd0;
                load_en = 1'b1; load_board = 64'd0;
            end else begin
                move_valid = 1'b0; load_en = 1'b0;
            end
            if (dut_board() != pre) changed = 1'b1;
        end
        move_valid = 1'b0;
        load_en    = 1'b0;
        chk_eq("vb_hold_unchanged", {63'd0, changed}, 64'd0);
        vblank = 1'b1;
        drain("left_drain");
        chk_eq("left_posK", {60'd0, posK}, 64'd0);
        chk_eq("left_posL", {60'd0, posL}, 64'd8);

        // Load a board with no blank, then the nearly-solved board
        load(64'h1111_1111_1111_1111, 4'd15);
        for (int i = 0; i < 14; i++) sb_board[i] = 4'(i + 1);
        sb_board[14] = 4'd0;
        sb_board[15] = 4'd15;
        load(sb_board, 4'd14);
        chk_eq("pre_solved", {63'd0, solved}, 64'd0);
        issue(2'd3);
        drain("solve_drain");
        @(negedge clk);
        chk_eq("solved_after", {63'd0, solved}, 64'd1);
        chk_eq("solved_count", 64'(move_count), 64'd1);
        issue(2'd1);
        drain("down_rej_drain");
        chk_eq("solved_kept", {63'd0, solved}, 64'd1);

        // Counter saturation: bounce the blank up and down
        do_reset();
        vblank = 1'b1;
        for (int i = 0; i < CMAX + 4; i++) issue((i % 2 == 0) ? 2'd0 : 2'd1);
        drain("sat_drain");
        chk_eq("sat_count", 64'(move_count), 64'(CMAX));

        // Reset during WAIT_VB drops the pending move
        do_reset();
        vblank = 1'b0;
        issue(2'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        exp_done--;
        vblank = 1'b1;
        repeat (6) @(negedge clk);
        chk_eq("rstwait_board", dut_board(), RST_BOARD);
        chk_eq("rstwait_count", 64'(move_count), 64'd0);
        chk_eq("rstwait_blank", {60'd0, blank_idx}, 64'd11);

        chk_eq("total_done", 64'(ndone), 64'(exp_done));
        chk_eq("total_rej", 64'(nrej), 64'(exp_rej));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
